// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage RV32 pipeline.
// Priority forwarding from FWD_STAGES downstream producers, load-use stall,
// redirect flush, multi-cycle execute handshake with timeout, stall counter.
module hazard_ctrl #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REG_AW-1:0]            d_rs1,
  input  logic [REG_AW-1:0]            d_rs2,
  input  logic                         d_use1,
  input  logic                         d_use2,
  input  logic [REG_AW-1:0]            e_rs1,
  input  logic [REG_AW-1:0]            e_rs2,
  input  logic [REG_AW-1:0]            e_rd,
  input  logic                         e_reg_write,
  input  logic                         e_is_load,
  input  logic                         e_mc_start,
  input  logic                         mc_done,
  input  logic                         redirect,
  input  logic [FWD_STAGES*REG_AW-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]        fwd_we,
  output logic                         pc_en,
  output logic                         f_d_en,
  output logic                         d_e_en,
  output logic                         f_d_flush,
  output logic                         d_e_flush,
  output logic                         e_bubble,
  output logic [SEL_W-1:0]             fwd_sel_a,
  output logic [SEL_W-1:0]             fwd_sel_b,
  output logic                         mc_busy,
  output logic                         mc_error,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int unsigned TMO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_TIMEOUT - 1);

  typedef enum logic [0:0] {ST_RUN, ST_MC_WAIT} state_t;

  state_t           state;
  state_t           next_state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_clr;
  logic             tmo_inc;
  logic             err_set;
  logic             load_use;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;

  // Nearest-first operand forwarding; loop runs far-to-near so the nearest match wins
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = int'(FWD_STAGES) - 1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_rd[k*REG_AW +: REG_AW] == e_rs1) && (e_rs1 != '0))
        sel_a = SEL_W'(k + 1);
      if (fwd_we[k] && (fwd_rd[k*REG_AW +: REG_AW] == e_rs2) && (e_rs2 != '0))
        sel_b = SEL_W'(k + 1);
    end
    fwd_sel_a = rst ? sel_a : '0;
    fwd_sel_b = rst ? sel_b : '0;
  end

  // Load in E whose destination is read by the instruction in D
  always_comb begin
    load_use = e_is_load && e_reg_write && (e_rd != '0) &&
               ((d_use1 && (d_rs1 == e_rd)) || (d_use2 && (d_rs2 == e_rd)));
  end

  // Next-state and pipeline control decode
  always_comb begin
    next_state = state;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    err_set    = 1'b0;
    pc_en      = 1'b0;
    f_d_en     = 1'b0;
    d_e_en     = 1'b0;
    f_d_flush  = 1'b0;
    d_e_flush  = 1'b0;
    e_bubble   = 1'b0;
    mc_busy    = 1'b0;
    if (!rst) begin
      f_d_flush  = 1'b1;
      d_e_flush  = 1'b1;
      e_bubble   = 1'b1;
      next_state = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (redirect) begin
            pc_en     = 1'b1;
            f_d_en    = 1'b1;
            d_e_en    = 1'b1;
            f_d_flush = 1'b1;
            d_e_flush = 1'b1;
          end else if (e_mc_start) begin
            next_state = ST_MC_WAIT;
            tmo_clr    = 1'b1;
            e_bubble   = 1'b1;
          end else if (load_use) begin
            d_e_en    = 1'b1;
            d_e_flush = 1'b1;
          end else begin
            pc_en  = 1'b1;
            f_d_en = 1'b1;
            d_e_en = 1'b1;
          end
        end
        ST_MC_WAIT: begin
          mc_busy  = 1'b1;
          e_bubble = 1'b1;
          tmo_inc  = 1'b1;
          if (mc_done) begin
            e_bubble   = 1'b0;
            next_state = ST_RUN;
          end else if (tmo_cnt == TMO_LAST) begin
            err_set    = 1'b1;
            d_e_flush  = 1'b1;
            next_state = ST_RUN;
          end
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  // State, timeout counter and sticky error
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_RUN;
      tmo_cnt  <= '0;
      mc_error <= 1'b0;
    end else begin
      state <= next_state;
      if (tmo_clr)
        tmo_cnt <= '0;
      else if (tmo_inc)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (err_set)
        mc_error <= 1'b1;
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt <= '0;
    else if (!pc_en && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MC_TIMEOUT=8), with a narrow
// second instance sharing the stimulus to exercise stall counter saturation.
module tb_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned FWD_STAGES = 2;
  localparam int unsigned SEL_W = 2;

  logic clk, rst;
  logic [REG_AW-1:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd;
  logic d_use1, d_use2, e_reg_write, e_is_load, e_mc_start, mc_done, redirect;
  logic [FWD_STAGES*REG_AW-1:0] fwd_rd;
  logic [FWD_STAGES-1:0] fwd_we;
  logic pc_en, f_d_en, d_e_en, f_d_flush, d_e_flush, e_bubble, mc_busy, mc_error;
  logic [SEL_W-1:0] fwd_sel_a, fwd_sel_b;
  logic [31:0] stall_cnt;
  logic pc_en2, f_d_en2, d_e_en2, f_d_flush2, d_e_flush2, e_bubble2, mc_busy2, mc_error2;
  logic [SEL_W-1:0] fwd_sel_a2, fwd_sel_b2;
  logic [2:0] stall_cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;
  int busy_cycles;

  hazard_ctrl #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W),
                .MC_TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use1(d_use1), .d_use2(d_use2),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd), .e_reg_write(e_reg_write),
    .e_is_load(e_is_load), .e_mc_start(e_mc_start), .mc_done(mc_done), .redirect(redirect),
    .fwd_rd(fwd_rd), .fwd_we(fwd_we), .pc_en(pc_en), .f_d_en(f_d_en), .d_e_en(d_e_en),
    .f_d_flush(f_d_flush), .d_e_flush(d_e_flush), .e_bubble(e_bubble),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .mc_busy(mc_busy),
    .mc_error(mc_error), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W),
                .MC_TIMEOUT(8), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use1(d_use1), .d_use2(d_use2),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd), .e_reg_write(e_reg_write),
    .e_is_load(e_is_load), .e_mc_start(e_mc_start), .mc_done(mc_done), .redirect(redirect),
    .fwd_rd(fwd_rd), .fwd_we(fwd_we), .pc_en(pc_en2), .f_d_en(f_d_en2), .d_e_en(d_e_en2),
    .f_d_flush(f_d_flush2), .d_e_flush(d_e_flush2), .e_bubble(e_bubble2),
    .fwd_sel_a(fwd_sel_a2), .fwd_sel_b(fwd_sel_b2), .mc_busy(mc_busy2),
    .mc_error(mc_error2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    d_rs1 = '0; d_rs2 = '0; d_use1 = 0; d_use2 = 0;
    e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_reg_write = 0; e_is_load = 0;
    e_mc_start = 0; mc_done = 0; redirect = 0; fwd_rd = '0; fwd_we = '0;
  endtask

  task automatic check_stall(input string tag);
    check({tag, "_cnt"}, stall_cnt, 32'(exp_stall));
    check({tag, "_sat"}, 32'(stall_cnt2), (exp_stall > 7) ? 32'd7 : 32'(exp_stall));
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();

    // Reset held three cycles with random inputs
    for (int i = 0; i < 3; i++) begin
      d_rs1 = 5'($urandom); d_rs2 = 5'($urandom); d_use1 = 1'($urandom); d_use2 = 1'($urandom);
      e_rs1 = 5'($urandom); e_rs2 = 5'($urandom); e_rd = 5'($urandom);
      e_reg_write = 1'($urandom); e_is_load = 1'($urandom); e_mc_start = 1'($urandom);
      mc_done = 1'($urandom); redirect = 1'($urandom);
      fwd_rd = 10'($urandom); fwd_we = 2'($urandom);
      #1;
      check("rst_pc_en", pc_en, 0);
      check("rst_f_d_flush", f_d_flush, 1);
      check("rst_d_e_flush", d_e_flush, 1);
      check("rst_e_bubble", e_bubble, 1);
      check("rst_fwd_sel_a", fwd_sel_a, 0);
      check("rst_mc_busy", mc_busy, 0);
      tick();
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_mc_error", mc_error, 0);
    end

    drive_idle();
    rst = 1'b1;
    #1;
    check("run_pc_en", pc_en, 1);
    check("run_d_e_en", d_e_en, 1);
    check("run_flush", {31'd0, f_d_flush | d_e_flush}, 0);
    check("run_e_bubble", e_bubble, 0);
    tick();
    check_stall("run");

    // Forwarding priority
    e_rs1 = 5'd5; fwd_rd = {5'd5, 5'd5}; fwd_we = 2'b11; #1;
    check("fwd_near", fwd_sel_a, 1);
    fwd_we = 2'b10; #1;
    check("fwd_far", fwd_sel_a, 2);
    fwd_we = 2'b00; #1;
    check("fwd_none", fwd_sel_a, 0);
    e_rs1 = 5'd0; fwd_rd = {5'd0, 5'd0}; fwd_we = 2'b11; #1;
    check("fwd_x0", fwd_sel_a, 0);
    e_rs2 = 5'd9; fwd_rd = {5'd9, 5'd3}; fwd_we = 2'b11; #1;
    check("fwd_b_far", fwd_sel_b, 2);
    check("fwd_b_pc", pc_en, 1);
    tick();

    // Load-use stall
    drive_idle();
    e_is_load = 1; e_reg_write = 1; e_rd = 5'd7; d_use2 = 1; d_rs2 = 5'd7; #1;
    check("lu_pc_en", pc_en, 0);
    check("lu_f_d_en", f_d_en, 0);
    check("lu_d_e_flush", d_e_flush, 1);
    tick(); exp_stall = 1;
    check_stall("lu");
    e_is_load = 0; #1;
    check("lu_after_pc_en", pc_en, 1);
    tick();
    check_stall("lu_after");
    e_is_load = 1; d_use2 = 0; #1;
    check("lu_unused_pc_en", pc_en, 1);
    e_rd = 5'd0; d_rs2 = 5'd0; d_use2 = 1; #1;
    check("lu_x0_pc_en", pc_en, 1);
    tick();

    // Redirect overrides load-use and multi-cycle start
    drive_idle();
    e_is_load = 1; e_reg_write = 1; e_rd = 5'd3; d_use1 = 1; d_rs1 = 5'd3; redirect = 1; #1;
    check("rd_f_d_flush", f_d_flush, 1);
    check("rd_d_e_flush", d_e_flush, 1);
    check("rd_pc_en", pc_en, 1);
    tick();
    check_stall("rd");
    drive_idle(); redirect = 1; e_mc_start = 1; tick();
    drive_idle(); #1;
    check("rd_mc_ignored", mc_busy, 0);
    tick();

    // Multi-cycle op, done on the 4th wait cycle; redirect ignored while waiting
    e_mc_start = 1; #1;
    check("mc_start_pc_en", pc_en, 0);
    check("mc_start_bubble", e_bubble, 1);
    check("mc_start_busy", mc_busy, 0);
    tick();
    e_mc_start = 0;
    busy_cycles = 0;
    for (int i = 1; i <= 4; i++) begin
      mc_done = (i == 4);
      redirect = (i == 2);
      #1;
      busy_cycles += int'(mc_busy);
      check("mc_wait_pc_en", pc_en, 0);
      check("mc_wait_bubble", e_bubble, (i == 4) ? 32'd0 : 32'd1);
      tick();
    end
    drive_idle(); #1;
    check("mc_busy_cycles", 32'(busy_cycles), 4);
    check("mc_exit_busy", mc_busy, 0);
    check("mc_exit_pc_en", pc_en, 1);
    exp_stall = 6;
    check_stall("mc");

    // Done coincides with the last timeout cycle: done wins
    e_mc_start = 1; tick(); e_mc_start = 0;
    for (int i = 1; i <= 8; i++) begin
      mc_done = (i == 8); #1;
      check("dt_busy", mc_busy, 1);
      check("dt_d_e_flush", d_e_flush, 0);
      if (i == 8) check("dt_bubble", e_bubble, 0);
      tick();
    end
    drive_idle(); #1;
    check("dt_mc_error", mc_error, 0);
    check("dt_exit_busy", mc_busy, 0);
    exp_stall = 15;
    check_stall("dt");

    // Timeout after 8 wait cycles
    e_mc_start = 1; tick(); e_mc_start = 0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      check("to_busy", mc_busy, 1);
      check("to_d_e_flush", d_e_flush, (i == 8) ? 32'd1 : 32'd0);
      check("to_bubble", e_bubble, 1);
      check("to_err_pending", mc_error, 0);
      tick();
    end
    #1;
    check("to_mc_error", mc_error, 1);
    check("to_exit_busy", mc_busy, 0);
    check("to_exit_pc_en", pc_en, 1);
    exp_stall = 24;
    check_stall("to");
    for (int i = 0; i < 3; i++) tick();
    check("to_sticky", mc_error, 1);

    // Reset while waiting aborts cleanly
    e_mc_start = 1; tick(); e_mc_start = 0; tick(); tick();
    check("rw_busy", mc_busy, 1);
    rst = 1'b0; #1;
    check("rw_rst_busy", mc_busy, 0);
    check("rw_rst_pc_en", pc_en, 0);
    tick();
    rst = 1'b1; #1;
    check("rw_busy_after", mc_busy, 0);
    check("rw_pc_en_after", pc_en, 1);
    check("rw_mc_error", mc_error, 0);
    exp_stall = 0;
    check_stall("rw");
    tick();
    check_stall("rw_run");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
